// File: rtl/data_mem_unit.sv
// -----------------------------------------------------------------------------
// data_mem_unit
//   MEM-stage data memory for the MIPS pipeline. Byte/half/word loads (sign or
//   zero extended) and byte-lane stores, with an optional fixed number of wait
//   states per access. Misaligned and out-of-range requests are rejected with a
//   one-cycle exception pulse. Also registers the branch-taken decision.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   WAIT_STATES  extra cycles per access, 0..15
//   AW           word-index width, derived from DEPTH_WORDS
//
// Ports
//   clk                  rising-edge clock
//   reset                asynchronous, active-low reset
//   ctrl_memRead         load request
//   ctrl_memWrite        store request (wins when both request bits are set)
//   access_size          00 byte, 01 half, 10 word, 11 treated as word
//   load_unsigned        1 = zero-extend loads (lbu/lhu)
//   mem_address          byte address
//   write_data_into_mem  store data, low byte/half used for sb/sh
//   ctrl_branch, zero    branch in MEM and ALU zero flag
//   ctrl_pcSrc           registered branch-taken
//   read_data_from_mem   registered, extended load result
//   rd_valid             one-cycle pulse when read_data_from_mem is updated
//   stall                combinational; MEM inputs must be held while high
//   misalign_exc         one-cycle pulse on a misaligned request
//   range_exc            one-cycle pulse on an address beyond DEPTH_WORDS
// -----------------------------------------------------------------------------
module data_mem_unit #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_memRead,
    input  logic        ctrl_memWrite,
    input  logic [1:0]  access_size,
    input  logic        load_unsigned,
    input  logic [31:0] mem_address,
    input  logic [31:0] write_data_into_mem,
    input  logic        ctrl_branch,
    input  logic        zero,
    output logic        ctrl_pcSrc,
    output logic [31:0] read_data_from_mem,
    output logic        rd_valid,
    output logic        stall,
    output logic        misalign_exc,
    output logic        range_exc
);

    localparam bit         HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [31:0] mem [DEPTH_WORDS];

    // Request captured at the accept edge; used only by the WAIT path.
    logic          cap_store;
    logic          cap_unsigned;
    logic [1:0]    cap_size;
    logic [AW+1:0] cap_addr;
    logic [31:0]   cap_data;

    // ------------------------------------------------------------------
    // Request decode (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic req, misalign, out_of_range, legal;

    always_comb begin
        req          = ctrl_memRead | ctrl_memWrite;
        misalign     = ((access_size == 2'b01) && mem_address[0]) ||
                       (access_size[1] && (mem_address[1:0] != 2'b00));
        out_of_range = (mem_address >> (AW + 2)) != 32'd0;
        legal        = (state == S_IDLE) && req && !misalign && !out_of_range;
    end

    assign stall = (legal && HAS_WAIT) || ((state == S_WAIT) && (wait_cnt > 4'd1));

    // ------------------------------------------------------------------
    // Access selection: live inputs for a zero-wait access, captured copy
    // for the final WAIT cycle.
    // ------------------------------------------------------------------
    logic          acc_fire, acc_store, acc_unsigned;
    logic [1:0]    acc_size;
    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_data;

    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_fire     = 1'b0;
        acc_store    = ctrl_memWrite;
        acc_unsigned = load_unsigned;
        acc_size     = access_size;
        acc_addr     = mem_address[AW+1:0];
        acc_data     = write_data_into_mem;
        if (state == S_WAIT) begin
            acc_fire     = (wait_cnt == 4'd1);
            acc_store    = cap_store;
            acc_unsigned = cap_unsigned;
            acc_size     = cap_size;
            acc_addr     = cap_addr;
            acc_data     = cap_data;
        end else begin
            acc_fire = legal && !HAS_WAIT;
        end
    end

    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [31:0]   load_ext;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lanes;

    assign word_idx = acc_addr[AW+1:2];
    assign rd_word  = mem[word_idx];
    assign sel_byte = rd_word[{acc_addr[1:0], 3'b000} +: 8];
    assign sel_half = rd_word[{acc_addr[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = rd_word;
        case (acc_size)
            2'b00:   load_ext = {{24{~acc_unsigned & sel_byte[7]}}, sel_byte};
            2'b01:   load_ext = {{16{~acc_unsigned & sel_half[15]}}, sel_half};
            default: load_ext = rd_word;
        endcase
    end

    // Store data is replicated across lanes; byte_en picks the addressed ones.
    always_comb begin
        byte_en  = 4'b1111;
        wr_lanes = acc_data;
        case (acc_size)
            2'b00: begin
                byte_en  = 4'b0001 << acc_addr[1:0];
                wr_lanes = {4{acc_data[7:0]}};
            end
            2'b01: begin
                byte_en  = 4'b0011 << {acc_addr[1], 1'b0};
                wr_lanes = {2{acc_data[15:0]}};
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= S_IDLE;
            wait_cnt           <= 4'd0;
            ctrl_pcSrc         <= 1'b0;
            read_data_from_mem <= 32'd0;
            rd_valid           <= 1'b0;
            misalign_exc       <= 1'b0;
            range_exc          <= 1'b0;
            cap_store          <= 1'b0;
            cap_unsigned       <= 1'b0;
            cap_size           <= 2'b00;
            cap_addr           <= '0;
            cap_data           <= 32'd0;
        end else begin
            ctrl_pcSrc   <= ctrl_branch & zero;
            rd_valid     <= acc_fire && !acc_store;
            misalign_exc <= (state == S_IDLE) && req && misalign;
            range_exc    <= (state == S_IDLE) && req && !misalign && out_of_range;
            if (acc_fire && !acc_store) begin
                read_data_from_mem <= load_ext;
            end
            case (state)
                S_IDLE: begin
                    if (legal && HAS_WAIT) begin
                        state        <= S_WAIT;
                        wait_cnt     <= WAIT_INIT;
                        cap_store    <= ctrl_memWrite;
                        cap_unsigned <= load_unsigned;
                        cap_size     <= access_size;
                        cap_addr     <= mem_address[AW+1:0];
                        cap_data     <= write_data_into_mem;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // NOTE: the memory must read back as zero after reset, so it is built
    // from resettable flops rather than an inferred RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (acc_fire && acc_store) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Parametrised MEM-stage data memory for the MIPS pipeline.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads and byte-lane writes on stores.
- Inserts a configurable number of wait states, signalled to the hazard unit through a stall output.
- Flags misaligned and out-of-range accesses, and registers the branch-taken decision (ctrl_pcSrc) for the fetch stage.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, at least 4.
- WAIT_STATES, 0: extra cycles per access, range 0..15.
- AW, $clog2(DEPTH_WORDS): word-index width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- ctrl_memRead  input  1  load request
- ctrl_memWrite  input  1  store request
- access_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- load_unsigned  input  1  1 = zero-extend on load (lbu/lhu)
- mem_address  input  32  byte address
- write_data_into_mem  input  32  store data; low byte/half used for sb/sh
- ctrl_branch  input  1  branch instruction in MEM
- zero  input  1  ALU zero flag
- ctrl_pcSrc  output  1  registered branch-taken
- read_data_from_mem  output  32  extended load result
- rd_valid  output  1  one-cycle pulse: read_data_from_mem updated
- stall  output  1  combinational; pipeline must hold MEM inputs
- misalign_exc  output  1  one-cycle pulse: misaligned access
- range_exc  output  1  one-cycle pulse: address beyond DEPTH_WORDS

Behaviour:
- Reset (reset=0, async):
  - all memory words 0; state IDLE; wait counter 0.
  - ctrl_pcSrc, read_data_from_mem, rd_valid, misalign_exc, range_exc all 0.
  - Reset mid-access aborts it: no write, no rd_valid.
- ctrl_pcSrc <= ctrl_branch & zero on every rising edge, independent of stall.
- Request: ctrl_memRead | ctrl_memWrite while in IDLE.
  - If both are set, the request is a store; no rd_valid.
  - Address, size, data and type are captured at the accept edge; later input changes are ignored until completion.
- Address decode:
  - word index = mem_address[AW+1:2].
  - range error if mem_address[31:AW+2] != 0.
  - misalign: half with addr[0]=1; word/reserved with addr[1:0]!=0.
  - Misalign takes priority over range.
- Error request:
  - no stall, no memory change, read_data_from_mem unchanged.
  - the corresponding exc pulse is high the cycle after the request edge; FSM stays IDLE.
- FSM states and transitions:
  - IDLE: on a legal request with WAIT_STATES=0, perform the access at this edge and stay IDLE. With WAIT_STATES>0, load counter=WAIT_STATES and go to WAIT.
  - WAIT: decrement counter each edge; when counter reaches 1, perform the captured access at that edge and return to IDLE.
- stall:
  - high while (IDLE & legal request & WAIT_STATES>0) or (WAIT & counter>1).
  - A legal request held from cycle 0 therefore sees stall high in cycles 0..WAIT_STATES-1 and low in cycle WAIT_STATES; the access completes at the end of cycle WAIT_STATES.
  - Requests in the cycle after completion are treated as new requests.
- Load:
  - Little-endian lanes: lane k = bits 8k+7:8k, k = addr[1:0] (byte) or {addr[1],0} (half).
  - Result is sign-extended unless load_unsigned.
  - read_data_from_mem is registered at the completion edge; rd_valid=1 for the following cycle only.
  - read_data_from_mem holds its value otherwise.
- Store:
  - Only the addressed lanes are written at the completion edge: sb writes 1 lane with data[7:0], sh writes 2 lanes with data[15:0], sw writes all 4.
- Load immediately following a store to the same word returns the new data. There is no write-to-read forwarding within a single access.

Test Plan:
- Reset, then sw 0x8000_00F1 to addr 0x10, lw 0x10 (WAIT_STATES=0) -> read_data_from_mem=0x8000_00F1, rd_valid one cycle after the load edge, stall never high.
- sb 0xAB to 0x21; lb 0x21 -> 0xFFFF_FFAB; lbu 0x21 -> 0x0000_00AB; lw 0x20 -> 0x0000_AB00.
- sh 0x1234 to 0x32, then lh 0x32 -> 0x0000_1234; lh 0x31 -> misalign_exc pulse, memory unchanged, stall=0; lw 0x1000 with DEPTH_WORDS=1024 -> range_exc pulse.
- WAIT_STATES=3, lw held from cycle 0 -> stall high in cycles 0-2, low in cycle 3, rd_valid in cycle 4; inputs changed in cycle 1 are ignored.
- ctrl_branch=1, zero=1 during a stalled access -> ctrl_pcSrc=1 after the next edge; zero=0 -> 0 after the following edge.
- WAIT_STATES=2, sw in progress, reset pulsed low in cycle 1 -> target word reads back 0, all outputs 0, FSM IDLE.
